muller_c_hs_driver: RTL and testbench
=====================================

// Module: muller_c_hs_driver
// PURPOSE
//  Clocked 4-phase handshake driver and checker for the Muller C-element stage.
//  Drives the element's two inputs with a programmable skew and samples its
//  asynchronous output through a 2-flop synchroniser. It flags hold violations
//  and missing transitions, and counts completed handshakes.
//  Sits directly upstream of the C-element: a_o/b_o feed it and c_i is its output.
// PARAMETERS
//  SKEW_W   4    width of skew_i: cycles between a_o and b_o edges
//  TO_CYC   64   wait-state cycles allowed for c_s to transition (>=4)
//  CNT_W    8    width of handshake counter hs_cnt_o
// PORTS
//  wb_clk_i    in   1       single clock, all state on rising edge
//  wb_rst_n    in   1       asynchronous active-low reset
//  start_i     in   1       request one full handshake, sampled in IDLE only
//  skew_i      in   SKEW_W  a-to-b edge skew in cycles, latched on accepted start
//  clr_i       in   1       clear sticky error flags
//  c_i         in   1       C-element output, asynchronous to wb_clk_i
//  a_o         out  1       C-element input A
//  b_o         out  1       C-element input B
//  busy_o      out  1       1 whenever FSM != IDLE
//  done_o      out  1       1-cycle pulse on handshake completion
//  err_hold_o  out  1       sticky: c_s changed while only A had switched
//  err_to_o    out  1       sticky: c_s failed to transition within TO_CYC
//  hs_cnt_o    out  CNT_W   completed handshakes, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async assert, sync release): all flops 0; FSM=IDLE; all outputs 0.
//  Sync: c_s = c_i after two flops (2-cycle latency). Only c_s is used.
//  FSM is Moore. a_o/b_o are registered; a/b are 1 in RISE_A(a only),
//   RISE_B, WAIT_HI and FALL_A(b only); 0 elsewhere.
//  IDLE: start_i=1 -> latch skew_q=skew_i. skew_q=0 -> RISE_B, else RISE_A.
//   So a_o rises at cycle N+1 for start_i at N.
//  RISE_A: a_o=1, b_o=0; skew counter runs skew_q cycles, then RISE_B.
//   c_s=1 here -> set err_hold_o; FSM continues.
//  RISE_B: a_o=b_o=1 for one cycle -> WAIT_HI; wait counter cleared.
//  WAIT_HI: c_s=1 -> FALL_A (skew_q=0: straight to FALL_B).
//   Wait counter reaches TO_CYC-1 -> set err_to_o, abort.
//  FALL_A: a_o=0, b_o=1 for skew_q cycles; c_s=0 here -> set err_hold_o; -> FALL_B.
//  FALL_B: a_o=b_o=0 for one cycle -> WAIT_LO; wait counter cleared.
//  WAIT_LO: c_s=0 -> done_o=1 next cycle, hs_cnt_o+1, -> IDLE. Timeout as WAIT_HI.
//  Abort: registered a_o=b_o=0 next cycle, FSM->IDLE, no done_o, no count.
//  start_i while busy_o=1 is ignored and not queued. skew_i changes mid-op ignored.
//  hs_cnt_o wraps (2^CNT_W-1)+1 -> 0 with no flag.
//  clr_i clears both sticky flags. Same-cycle set and clear: set wins.
//  Reset mid-handshake: a_o/b_o drop to 0 asynchronously; no done_o; count -> 0.
// TESTING
//  T1 Ideal C-model (2-cycle delay), skew=0, start pulse at cycle 10 ->
//   a_o=b_o=1 at 11; done_o pulses once; hs_cnt_o=1; no errors.
//  T2 skew=3 -> b_o rises exactly 3 cycles after a_o and falls 3 cycles after a_o.
//   done_o pulses; no errors.
//  T3 Faulty model with c_i following a only, skew=5 -> err_hold_o=1 in RISE_A.
//   Handshake still completes. clr_i=1 -> 0 next cycle.
//  T4 c_i stuck 0, TO_CYC=64 -> err_to_o=1 after 64 WAIT_HI cycles.
//   a_o=b_o=0 next cycle; busy_o=0; hs_cnt_o unchanged.
//  T5 CNT_W=8, 256 back-to-back handshakes -> hs_cnt_o wraps to 0.
//   start_i held high while busy does not add extra handshakes.
//  T6 wb_rst_n low during WAIT_HI -> a_o, b_o, busy_o, hs_cnt_o = 0 immediately.
//   After release, a new start completes normally.

Source files
------------

// File: rtl/muller_c_hs_driver.sv
// Clocked 4-phase handshake driver/checker for a Muller C-element stage.
// Drives A/B with programmable skew, watches the synchronised C output, counts handshakes.
module muller_c_hs_driver #(
    parameter int SKEW_W = 4,
    parameter int TO_CYC = 64,
    parameter int CNT_W  = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              start_i,
    input  logic [SKEW_W-1:0] skew_i,
    input  logic              clr_i,
    input  logic              c_i,
    output logic              a_o,
    output logic              b_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_hold_o,
    output logic              err_to_o,
    output logic [CNT_W-1:0]  hs_cnt_o
);

    localparam int WAIT_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE_A  = 3'd1,
        RISE_B  = 3'd2,
        WAIT_HI = 3'd3,
        FALL_A  = 3'd4,
        FALL_B  = 3'd5,
        WAIT_LO = 3'd6
    } state_e;

    // Reset asserts asynchronously but is released on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rst_sync_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values, independent of statement order.
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Two-flop synchroniser for the asynchronous C-element output.
    logic c_meta_q;
    logic c_s_q;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            c_meta_q <= 1'b0;
            c_s_q    <= 1'b0;
        end else begin
            c_meta_q <= c_i;
            c_s_q    <= c_meta_q;
        end
    end

    state_e              state_q, state_d;
    logic [SKEW_W-1:0]   skew_q, skew_d;
    logic [SKEW_W-1:0]   skew_cnt_q, skew_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                a_q, a_d;
    logic                b_q, b_d;
    logic                done_q;
    logic                err_hold_q, err_hold_d;
    logic                err_to_q, err_to_d;
    logic [CNT_W-1:0]    hs_cnt_q;
    logic                set_hold;
    logic                set_to;
    logic                hs_done;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        skew_d     = skew_q;
        skew_cnt_d = '0;
        wait_cnt_d = '0;
        set_hold   = 1'b0;
        set_to     = 1'b0;
        hs_done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    skew_d  = skew_i;
                    state_d = (skew_i == '0) ? RISE_B : RISE_A;
                end
            end
            RISE_A: begin
                if (c_s_q) set_hold = 1'b1;
                if (skew_cnt_q == skew_q - SKEW_W'(1)) state_d = RISE_B;
                else skew_cnt_d = skew_cnt_q + SKEW_W'(1);
            end
            RISE_B: begin
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (c_s_q) begin
                    state_d = (skew_q == '0) ? FALL_B : FALL_A;
                end else if (wait_cnt_q == WAIT_W'(TO_CYC - 1)) begin
                    set_to  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            FALL_A: begin
                if (!c_s_q) set_hold = 1'b1;
                if (skew_cnt_q == skew_q - SKEW_W'(1)) state_d = FALL_B;
                else skew_cnt_d = skew_cnt_q + SKEW_W'(1);
            end
            FALL_B: begin
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!c_s_q) begin
                    hs_done = 1'b1;
                    state_d = IDLE;
                end else if (wait_cnt_q == WAIT_W'(TO_CYC - 1)) begin
                    set_to  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A/B are decoded from the next state so they change on the same edge as the FSM.
        a_d = (state_d == RISE_A) || (state_d == RISE_B) || (state_d == WAIT_HI);
        b_d = (state_d == RISE_B) || (state_d == WAIT_HI) || (state_d == FALL_A);

        // Set has priority over clear.
        err_hold_d = set_hold ? 1'b1 : (clr_i ? 1'b0 : err_hold_q);
        err_to_d   = set_to   ? 1'b1 : (clr_i ? 1'b0 : err_to_q);
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            skew_q     <= '0;
            skew_cnt_q <= '0;
            wait_cnt_q <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            done_q     <= 1'b0;
            err_hold_q <= 1'b0;
            err_to_q   <= 1'b0;
            hs_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            skew_q     <= skew_d;
            skew_cnt_q <= skew_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            done_q     <= hs_done;
            err_hold_q <= err_hold_d;
            err_to_q   <= err_to_d;
            hs_cnt_q   <= hs_cnt_q + CNT_W'(hs_done);
        end
    end

    assign a_o        = a_q;
    assign b_o        = b_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign err_hold_o = err_hold_q;
    assign err_to_o   = err_to_q;
    assign hs_cnt_o   = hs_cnt_q;

endmodule

// File: tb/tb_muller_c_hs_driver.sv
// Directed bench for muller_c_hs_driver: drives a behavioural C-element model
// (ideal, A-follower, stuck-at-0) and checks timing, errors and the counter.
module tb_muller_c_hs_driver;

    logic       wb_clk_i;
    logic       wb_rst_n;
    logic       start_i;
    logic [3:0] skew_i;
    logic       clr_i;
    logic       c_i;
    logic       a_o;
    logic       b_o;
    logic       busy_o;
    logic       done_o;
    logic       err_hold_o;
    logic       err_to_o;
    logic [7:0] hs_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    // 0: ideal C-element with 2-cycle delay, 1: follows A only, 2: stuck at 0
    int   mode = 0;
    logic c_st;
    logic c_dl;

    muller_c_hs_driver #(.SKEW_W(4), .TO_CYC(64), .CNT_W(8)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n   (wb_rst_n),
        .start_i    (start_i),
        .skew_i     (skew_i),
        .clr_i      (clr_i),
        .c_i        (c_i),
        .a_o        (a_o),
        .b_o        (b_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_hold_o (err_hold_o),
        .err_to_o   (err_to_o),
        .hs_cnt_o   (hs_cnt_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            c_st <= 1'b0;
            c_dl <= 1'b0;
        end else begin
            c_st <= (a_o & b_o) | (c_st & (a_o | b_o));
            c_dl <= c_st;
        end
    end

    assign c_i = (mode == 2) ? 1'b0 : (mode == 1) ? a_o : c_dl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Runs one handshake; cycle numbers count edges after start_i is raised (first edge = 1).
    task automatic run_hs(input logic [3:0] skew, input logic clr_hold, input int re_at,
                          output int a_r, output int b_r, output int a_f, output int b_f,
                          output int n_done, output int n_cyc, output logic hold_seen);
        logic a_p;
        logic b_p;
        a_r = -1; b_r = -1; a_f = -1; b_f = -1;
        n_done = 0; n_cyc = 0; hold_seen = 1'b0;
        a_p = a_o; b_p = b_o;
        skew_i = skew;
        clr_i  = clr_hold;
        for (int i = 1; i <= 400; i++) begin
            start_i = (i == 1) || (i == re_at);
            tick();
            if (i == 1) skew_i = 4'hF;
            if (a_o && !a_p) a_r = i;
            if (b_o && !b_p) b_r = i;
            if (!a_o && a_p) a_f = i;
            if (!b_o && b_p) b_f = i;
            if (done_o) n_done++;
            if (err_hold_o) hold_seen = 1'b1;
            a_p = a_o; b_p = b_o;
            n_cyc = i;
            if (!busy_o) break;
        end
        start_i = 1'b0;
        clr_i   = 1'b0;
        check("hs_terminates", busy_o, 1'b0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   a_r, b_r, a_f, b_f, n_done, n_cyc;
        logic hold_seen;

        wb_rst_n = 1'b0;
        start_i  = 1'b0;
        skew_i   = 4'd0;
        clr_i    = 1'b0;
        repeat (3) tick();
        check("rst_a",    a_o, 0);
        check("rst_b",    b_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_errs", {err_hold_o, err_to_o}, 0);
        check("rst_cnt",  hs_cnt_o, 0);
        wb_rst_n = 1'b1;
        repeat (6) tick();
        check("post_rst_idle", busy_o, 0);

        // T1: ideal model, zero skew
        mode = 0;
        run_hs(4'd0, 1'b0, 0, a_r, b_r, a_f, b_f, n_done, n_cyc, hold_seen);
        check("t1_a_rise", a_r, 1);
        check("t1_b_rise", b_r, 1);
        check("t1_fall_together", b_f - a_f, 0);
        check("t1_done_once", n_done, 1);
        check("t1_len", n_cyc, 11);
        check("t1_cnt", hs_cnt_o, 1);
        check("t1_errs", {err_hold_o, err_to_o}, 0);
        tick();
        check("t1_done_pulse", done_o, 0);

        // T2: skew 3, skew_i changed after start must not matter
        run_hs(4'd3, 1'b0, 0, a_r, b_r, a_f, b_f, n_done, n_cyc, hold_seen);
        check("t2_a_rise", a_r, 1);
        check("t2_rise_skew", b_r - a_r, 3);
        check("t2_fall_skew", b_f - a_f, 3);
        check("t2_done", n_done, 1);
        check("t2_cnt", hs_cnt_o, 2);
        check("t2_errs", {err_hold_o, err_to_o}, 0);

        // T3: C follows A only, skew 5 -> hold error during RISE_A, still completes
        mode = 1;
        run_hs(4'd5, 1'b0, 0, a_r, b_r, a_f, b_f, n_done, n_cyc, hold_seen);
        check("t3_hold", err_hold_o, 1);
        check("t3_done", n_done, 1);
        check("t3_cnt", hs_cnt_o, 3);
        check("t3_to", err_to_o, 0);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("t3_clr", err_hold_o, 0);

        // T3b: clear held throughout -> set wins while violating, cleared afterwards
        run_hs(4'd5, 1'b1, 0, a_r, b_r, a_f, b_f, n_done, n_cyc, hold_seen);
        check("t3b_set_wins", hold_seen, 1);
        check("t3b_cleared", err_hold_o, 0);
        check("t3b_cnt", hs_cnt_o, 4);

        // Start while busy is ignored and not queued
        mode = 0;
        run_hs(4'd1, 1'b0, 3, a_r, b_r, a_f, b_f, n_done, n_cyc, hold_seen);
        check("ign_done", n_done, 1);
        repeat (3) tick();
        check("ign_not_queued", busy_o, 0);
        check("ign_cnt", hs_cnt_o, 5);

        // T4: stuck at 0 -> timeout after 64 WAIT_HI cycles
        mode = 2;
        run_hs(4'd0, 1'b0, 0, a_r, b_r, a_f, b_f, n_done, n_cyc, hold_seen);
        check("t4_abort_cycle", n_cyc, 66);
        check("t4_to", err_to_o, 1);
        check("t4_ab_low", {a_o, b_o}, 0);
        check("t4_no_done", n_done, 0);
        check("t4_cnt", hs_cnt_o, 5);
        check("t4_hold", err_hold_o, 0);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("t4_clr", err_to_o, 0);

        // T6: reset during WAIT_HI clears outputs immediately
        start_i = 1'b1;
        skew_i  = 4'd0;
        tick();
        start_i = 1'b0;
        repeat (10) tick();
        check("t6_pre_busy", busy_o, 1);
        wb_rst_n = 1'b0;
        #1;
        check("t6_ab", {a_o, b_o}, 0);
        check("t6_busy", busy_o, 0);
        check("t6_cnt", hs_cnt_o, 0);
        check("t6_done", done_o, 0);
        #2;
        wb_rst_n = 1'b1;
        mode = 0;
        repeat (4) tick();
        run_hs(4'd2, 1'b0, 0, a_r, b_r, a_f, b_f, n_done, n_cyc, hold_seen);
        check("t6_after_done", n_done, 1);
        check("t6_after_skew", b_r - a_r, 2);
        check("t6_after_cnt", hs_cnt_o, 1);

        // T5: start held high, 256 back-to-back handshakes wrap the counter
        n_done  = 0;
        skew_i  = 4'd0;
        start_i = 1'b1;
        for (int i = 0; i < 256 * 30; i++) begin
            tick();
            if (done_o) begin
                n_done++;
                if (n_done == 255) check("t5_wrap", hs_cnt_o, 0);
                if (n_done == 256) break;
            end
        end
        start_i = 1'b0;
        check("t5_done_count", n_done, 256);
        repeat (3) tick();
        check("t5_idle", busy_o, 0);
        check("t5_cnt", hs_cnt_o, 1);
        check("t5_errs", {err_hold_o, err_to_o}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
